imem_loader: RTL and testbench

- Write-side counterpart of inst_mem, which the core only reads.
- Accepts a little-endian byte stream over a valid/ready handshake and assembles it into 32-bit instruction words.
- Drives the instruction memory write port at consecutive word addresses.
- Holds the core (PC, Registers, etc.) in reset until a complete program has been loaded.

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: takes a little-endian byte stream (16-bit word count, then words)
// and writes consecutive 32-bit words into the instruction memory, holding the core in reset until done.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_FLUSH, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] asm_q, asm_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, busy_q, done_q, err_q, core_rst_q;

    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] wcnt_inc;

    assign xfer     = byte_valid && ready_q;
    assign len_full = {byte_data, len_q[7:0]};
    assign wcnt_inc = wcnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = byte_data;
                    wcnt_d      = '0;
                    bcnt_d      = '0;
                    if (len_full == 16'd0)
                        state_d = S_DONE;
                    else if (32'(len_full) > MAX_WORDS)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: asm_d[7:0]   = byte_data;
                        2'd1: asm_d[15:8]  = byte_data;
                        2'd2: asm_d[23:16] = byte_data;
                        default: begin
                            // Word complete: the write fires in the following cycle.
                            we_d    = 1'b1;
                            waddr_d = BASE_ADDR + {14'd0, wcnt_q, 2'b00};
                            wdata_d = {byte_data, asm_q};
                            wcnt_d  = wcnt_inc;
                            if (wcnt_inc == len_q) state_d = S_FLUSH;
                        end
                    endcase
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            wcnt_q     <= '0;
            bcnt_q     <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= BASE_ADDR;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            bcnt_q     <= bcnt_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            // Status flags decode the next state so they line up with state_q.
            ready_q    <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
            busy_q     <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                          (state_d == S_DATA)   || (state_d == S_FLUSH);
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
            core_rst_q <= (state_d != S_DONE);
        end
    end

    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (BASE_ADDR 0x0 and 0x100) share one stimulus
// stream; expected writes are queued per instance and checked by independent monitors.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [7:0]  byte_data;

    logic        d0_ready, d0_we, d0_core_rst, d0_busy, d0_done, d0_err;
    logic [31:0] d0_waddr, d0_wdata;
    logic        d1_ready, d1_we, d1_core_rst, d1_busy, d1_done, d1_err;
    logic [31:0] d1_waddr, d1_wdata;

    int total = 0;
    int bad   = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(d0_ready), .imem_we(d0_we), .imem_waddr(d0_waddr), .imem_wdata(d0_wdata),
        .core_rst(d0_core_rst), .busy(d0_busy), .done(d0_done), .err(d0_err)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(256)) dut1 (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(d1_ready), .imem_we(d1_we), .imem_waddr(d1_waddr), .imem_wdata(d1_wdata),
        .core_rst(d1_core_rst), .busy(d1_busy), .done(d1_done), .err(d1_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every write pulse must match the head of its instance's queue.
    always @(negedge clk) begin
        if (d0_we) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL wr0_unexpected: got addr=%h data=%h expected no write", d0_waddr, d0_wdata);
            end else begin
                logic [63:0] e;
                e = q0.pop_front();
                chk("wr0", {d0_waddr, d0_wdata}, e);
            end
        end
    end

    always @(negedge clk) begin
        if (d1_we) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL wr1_unexpected: got addr=%h data=%h expected no write", d1_waddr, d1_wdata);
            end else begin
                logic [63:0] e;
                e = q1.pop_front();
                chk("wr1", {d1_waddr, d1_wdata}, e);
            end
        end
    end

    task automatic exp_wr(input logic [31:0] off, input logic [31:0] data);
        q0.push_back({32'h0000_0000 + off, data});
        q1.push_back({32'h0000_0100 + off, data});
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (!d0_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!d0_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: byte_ready=%b expected 1 within 50 cycles", d0_ready);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // Flags are {byte_ready, core_rst, busy, done, err}.
    task automatic chk_flags(input string name, input logic [4:0] exp);
        chk({name, "_0"}, {59'd0, d0_ready, d0_core_rst, d0_busy, d0_done, d0_err}, {59'd0, exp});
        chk({name, "_1"}, {59'd0, d1_ready, d1_core_rst, d1_busy, d1_done, d1_err}, {59'd0, exp});
    endtask

    task automatic chk_reset_vals(input string name);
        chk_flags(name, 5'b01000);
        chk({name, "_we"},   {62'd0, d0_we, d1_we}, 64'd0);
        chk({name, "_out0"}, {d0_waddr, d0_wdata}, {32'h0000_0000, 32'h0});
        chk({name, "_out1"}, {d1_waddr, d1_wdata}, {32'h0000_0100, 32'h0});
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_q0"}, 64'(q0.size()), 64'd0);
        chk({name, "_q1"}, 64'(q1.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        tick(3);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Basic load, byte_valid held high across bytes.
        exp_wr(32'h0, 32'h0050_0513);
        exp_wr(32'h4, 32'h00A5_05B3);
        pulse_start();
        chk_flags("lenlo", 5'b11100);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'h50); send(8'h00);
        send(8'hB3); send(8'h05); send(8'hA5); send(8'h00);
        chk_flags("flush", 5'b01100);
        tick(1);
        chk_flags("basic_done", 5'b00010);
        chk("basic_hold0", {d0_waddr, d0_wdata}, {32'h0000_0004, 32'h00A5_05B3});
        chk_drained("basic");

        // Zero length: straight to DONE.
        pulse_start();
        send(8'h00); send(8'h00);
        chk_flags("zero_done", 5'b00010);
        tick(3);
        chk_drained("zero");

        // Oversize length 257.
        pulse_start();
        send(8'h01); send(8'h01);
        chk_flags("oversize", 5'b01001);
        tick(3);
        chk_flags("oversize_hold", 5'b01001);
        pulse_start();
        chk_flags("err_restart", 5'b11100);
        chk_drained("oversize");

        // Reset from LEN_LO, then bytes offered in IDLE must not be consumed.
        do_reset();
        chk_reset_vals("rst_lenlo");
        byte_valid = 1'b1; byte_data = 8'h55;
        tick(3);
        chk_flags("idle_noready", 5'b01000);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        byte_valid = 1'b0;
        exp_wr(32'h0, 32'hDEAD_BEEF);
        send(8'h01); tick(2);
        send(8'h00); tick(1);
        send(8'hEF); tick(3);
        send(8'hBE); tick(1);
        send(8'hAD); tick(2);
        send(8'hDE);
        tick(1);
        chk_flags("gaps_done", 5'b00010);
        chk_drained("gaps");

        // Mid-load reset after the 6th data byte of a 3-word load.
        exp_wr(32'h0, 32'h4433_2211);
        pulse_start();
        send(8'h03); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        do_reset();
        chk_reset_vals("midrst");
        tick(5);
        chk_reset_vals("midrst_idle");
        chk_drained("midrst");
        exp_wr(32'h0, 32'hD4C3_B2A1);
        pulse_start();
        send(8'h01); send(8'h00);
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        tick(1);
        chk_flags("midrst_reload", 5'b00010);
        chk_drained("midrst_reload");

        // Reload from DONE: core goes back into reset immediately.
        pulse_start();
        chk_flags("redo_start", 5'b11100);
        exp_wr(32'h0, 32'h1234_5678);
        send(8'h01); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34);
        chk_flags("redo_mid", 5'b11100);
        send(8'h12);
        chk_flags("redo_flush", 5'b01100);
        tick(1);
        chk_flags("redo_done", 5'b00010);
        tick(2);
        chk_drained("redo");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
